sram_arbiter_2port: RTL

Shares one single-ported synchronous SRAM (the `sram_wrapper` interface: active-low cs/we/byte-enables, 1-cycle read latency) between two requesters, e.g. the CPU data port and the display/DMA engine. The block arbitrates address-phase requests, drives the RAM control signals, and tracks the outstanding read so that read data returns to the requester that issued it. It sits between the requesters and the RAM, with no added address-phase latency.

---
 rtl/sram_arbiter_2port_pkg.sv | 14 +
 rtl/sram_arb_pick.sv | 43 ++++
 rtl/sram_arbiter_2port.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_2port_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2port_pkg
// Purpose : Shared constants for the two-port SRAM arbiter slice.
// Contents: PORT_P0 / PORT_P1 - 1-bit requester indices used for winner,
//           owner, last-grant and read-return routing.
// Config  : SRAM_ARB_ROUND_ROBIN_EN (see sram_arbiter_2port) does not affect
//           this package.
// -----------------------------------------------------------------------------
package sram_arbiter_2port_pkg;

    localparam logic PORT_P0 = 1'b0;
    localparam logic PORT_P1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Purpose : Combinational winner select for the two-port SRAM arbiter.
// Ports   : req_i         - request vector, bit N = port N
//           owner_valid_i - a port currently holds the lock
//           owner_i       - index of the locking port
//           last_gnt_i    - port granted most recently (round-robin build only)
//           gnt_oh_o      - one-hot (or zero) grant, before reset masking
// Config  : SRAM_ARB_ROUND_ROBIN_EN defined -> contention goes to the port not
//           granted most recently; undefined -> p0 always wins contention.
// -----------------------------------------------------------------------------
module sram_arb_pick
    import sram_arbiter_2port_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       owner_valid_i,
    input  logic       owner_i,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    input  logic       last_gnt_i,
`endif
    output logic [1:0] gnt_oh_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives gnt_oh_o; a missed
        // branch in always_comb would otherwise infer a latch.
        gnt_oh_o = 2'b00;
        if (owner_valid_i) begin
            // Locked: only the owner can win; the other port stalls even if
            // the owner is idle this cycle.
            gnt_oh_o[owner_i] = req_i[owner_i];
        end else if (req_i == 2'b11) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            gnt_oh_o = (last_gnt_i == PORT_P0) ? 2'b10 : 2'b01;
`else
            gnt_oh_o = 2'b01;
`endif
        end else begin
            gnt_oh_o = req_i;
        end
    end

endmodule

// File: rtl/sram_arbiter_2port.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2port
// Purpose : Shares one single-ported synchronous SRAM (active-low controls,
//           1-cycle read latency) between two requesters. Grants are
//           combinational, the RAM address phase is the grant cycle, and read
//           data returns to the issuing port exactly one cycle later.
// Ports   : clk, rst (synchronous, active high)
//           pN_req/we/be/addr/wdata/lock (in)  - request from port N (N=0,1)
//           pN_gnt (out)                       - request accepted this cycle
//           pN_rvalid/rdata (out)              - read return for port N
//           sram_cs_n/we_n/be_n/addr/wdata     - RAM address phase (out)
//           sram_rdata (in)                    - RAM read data
// Config  : SRAM_ARB_ROUND_ROBIN_EN - round-robin on contention (adds last_gnt);
//           default build is fixed priority with p0 winning.
// -----------------------------------------------------------------------------
module sram_arbiter_2port
    import sram_arbiter_2port_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned BW    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p0_req,
    output logic             p0_gnt,
    input  logic             p0_we,
    input  logic [BW-1:0]    p0_be,
    input  logic [AW-1:0]    p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    input  logic             p0_lock,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,

    input  logic             p1_req,
    output logic             p1_gnt,
    input  logic             p1_we,
    input  logic [BW-1:0]    p1_be,
    input  logic [AW-1:0]    p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    input  logic             p1_lock,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,

    output logic             sram_cs_n,
    output logic             sram_we_n,
    output logic [BW-1:0]    sram_be_n,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    logic [1:0]       req;
    logic [1:0]       gnt_oh;
    logic [1:0]       gnt;
    logic             xfer;
    logic             sel;
    logic             sel_we;
    logic             sel_lock;
    logic [BW-1:0]    sel_be;

    logic             rd_pend_q,     rd_pend_d;
    logic             rd_port_q,     rd_port_d;
    logic             owner_valid_q, owner_valid_d;
    logic             owner_q,       owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic             last_gnt_q,    last_gnt_d;
`endif

    assign req = {p1_req, p0_req};

    sram_arb_pick u_pick (
        .req_i         (req),
        .owner_valid_i (owner_valid_q),
        .owner_i       (owner_q),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        .last_gnt_i    (last_gnt_q),
`endif
        .gnt_oh_o      (gnt_oh)
    );

    assign gnt    = rst ? 2'b00 : gnt_oh;
    assign p0_gnt = gnt[PORT_P0];
    assign p1_gnt = gnt[PORT_P1];
    assign xfer   = |gnt;

    // Winner index; with no grant this falls back to p0 so the idle address
    // and write-data buses follow p0 instead of toggling.
    assign sel      = gnt[PORT_P1];
    assign sel_we   = sel ? p1_we   : p0_we;
    assign sel_lock = sel ? p1_lock : p0_lock;
    assign sel_be   = sel ? p1_be   : p0_be;

    assign sram_addr  = sel ? p1_addr  : p0_addr;
    assign sram_wdata = sel ? p1_wdata : p0_wdata;
    assign sram_cs_n  = !xfer;
    assign sram_we_n  = !(xfer && sel_we);
    assign sram_be_n  = xfer ? ~sel_be : {BW{1'b1}};

    always_comb begin
        rd_pend_d     = xfer && !sel_we;
        rd_port_d     = sel;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        if (owner_valid_q && !req[owner_q]) begin
            // Owner let go of req: release at end of this (stalled) cycle.
            owner_valid_d = 1'b0;
        end else if (xfer) begin
            // Any grant re-evaluates ownership from the winner's lock bit;
            // a lock from the losing port is never looked at.
            owner_valid_d = sel_lock;
            owner_d       = sel;
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_gnt_d = xfer ? sel : last_gnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (rst) begin
            rd_pend_q     <= 1'b0;
            rd_port_q     <= PORT_P0;
            owner_valid_q <= 1'b0;
            owner_q       <= PORT_P0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_gnt_q    <= PORT_P0;
`endif
        end else begin
            rd_pend_q     <= rd_pend_d;
            rd_port_q     <= rd_port_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_gnt_q    <= last_gnt_d;
`endif
        end
    end

    // Gating with rst drops a read whose return cycle coincides with reset.
    assign p0_rvalid = rd_pend_q && (rd_port_q == PORT_P0) && !rst;
    assign p1_rvalid = rd_pend_q && (rd_port_q == PORT_P1) && !rst;
    assign p0_rdata  = sram_rdata;
    assign p1_rdata  = sram_rdata;

endmodule
